// File: rtl/motor_pkg.sv
// -----------------------------------------------------------------------------
// motor_pkg
//
// Purpose : Shared types and helpers for the multi-channel limit-switch motor
//           controller (motor_chan / motor_ctrl_multi).
//
// Contents:
//   motor_st_e   - per-channel controller state
//   motor_dir_e  - travel direction
//   run_state()  - maps a direction onto its running state
//   opposite()   - reverses a direction
// -----------------------------------------------------------------------------
package motor_pkg;

  // Per-channel controller states.
  typedef enum logic [2:0] {
    IDLE,
    RUN_UP,
    RUN_DN,
    DEAD,
    FAULT
  } motor_st_e;

  // Direction of travel, used for the pending direction across a reversal.
  typedef enum logic {
    DIR_UP,
    DIR_DN
  } motor_dir_e;

  // Running state that drives the motor in the given direction.
  function automatic motor_st_e run_state(input motor_dir_e dir);
    return (dir == DIR_UP) ? RUN_UP : RUN_DN;
  endfunction

  // Opposite direction of travel.
  function automatic motor_dir_e opposite(input motor_dir_e dir);
    return (dir == DIR_UP) ? DIR_DN : DIR_UP;
  endfunction

endpackage : motor_pkg

// File: rtl/motor_chan.sv
// -----------------------------------------------------------------------------
// motor_chan
//
// Purpose : One limit-switch motor channel. A rising edge on `activate`
//           drives the motor toward the opposite end-stop; a second press while
//           running reverses direction through a dead-time interval with both
//           drives low. A run watchdog and a contradictory-limit check latch the
//           channel into FAULT until acknowledged.
//
// Ports   :
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   activate   in   request level, rising edge acts
//   up_limit   in   upper end-stop, active-high
//   dn_limit   in   lower end-stop, active-high
//   timeout    in   [TMO_W] max motor-on cycles per travel, 0 = no watchdog
//   fault_clr  in   fault acknowledge, level
//   motor_up   out  drive up
//   motor_dn   out  drive down
//   busy       out  channel running or in dead time
//   fault      out  channel latched in FAULT
// -----------------------------------------------------------------------------
module motor_chan
  import motor_pkg::*;
#(
  parameter int unsigned TMO_W       = 16,
  parameter int unsigned DEAD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             activate,
  input  logic             up_limit,
  input  logic             dn_limit,
  input  logic [TMO_W-1:0] timeout,
  input  logic             fault_clr,
  output logic             motor_up,
  output logic             motor_dn,
  output logic             busy,
  output logic             fault
);

  // Dead counter runs 0 .. DEAD_CYCLES-1; the last value hands over to RUN.
  localparam int unsigned     DCW       = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DCW-1:0]  DEAD_LAST = DCW'(DEAD_CYCLES - 1);

  motor_st_e        state;
  motor_dir_e       pend_dir;
  logic             act_q;
  logic [TMO_W-1:0] run_cnt;
  logic [DCW-1:0]   dead_cnt;

  logic act_rise;
  logic both_lim;
  logic target_lim;
  logic wdog_hit;

  assign act_rise = activate & ~act_q;

  // Both end-stops at once is physically impossible and marks a wiring or
  // sensor fault; it overrides every other condition.
  assign both_lim = up_limit & dn_limit;

  // Only the limit in the direction of travel stops the motor; the other one
  // is normally still asserted just after departure.
  assign target_lim = (state == RUN_UP) ? up_limit : dn_limit;

  // run_cnt holds the number of completed RUN cycles, so matching timeout-1
  // means the drive has been high for exactly `timeout` cycles by this edge.
  assign wdog_hit = (timeout != '0) && (run_cnt == (timeout - TMO_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pend_dir <= DIR_UP;
      // Reset high so a request held through reset needs a fresh edge.
      act_q    <= 1'b1;
      run_cnt  <= '0;
      dead_cnt <= '0;
    end else begin
      act_q <= activate;
      unique case (state)
        IDLE: begin
          if (both_lim) begin
            state <= FAULT;
          end else if (act_rise) begin
            // Sitting on the upper stop means the only way is down.
            state   <= up_limit ? RUN_DN : RUN_UP;
            run_cnt <= '0;
          end
        end

        RUN_UP, RUN_DN: begin
          if (both_lim) begin
            state <= FAULT;
          end else if (target_lim) begin
            // A simultaneous press is consumed here and does not restart.
            state <= IDLE;
          end else if (wdog_hit) begin
            state <= FAULT;
          end else if (act_rise) begin
            state    <= DEAD;
            pend_dir <= (state == RUN_UP) ? DIR_DN : DIR_UP;
            dead_cnt <= '0;
          end else begin
            run_cnt <= run_cnt + TMO_W'(1);
          end
        end

        DEAD: begin
          if (both_lim) begin
            state <= FAULT;
          end else if (dead_cnt == DEAD_LAST) begin
            state   <= run_state(pend_dir);
            run_cnt <= '0;
          end else begin
            dead_cnt <= dead_cnt + DCW'(1);
          end
        end

        FAULT: begin
          if (fault_clr && !both_lim) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Drives decode straight from the state register, so up and down can never
  // be high together: they correspond to two distinct state values.
  assign motor_up = (state == RUN_UP);
  assign motor_dn = (state == RUN_DN);
  assign busy     = (state == RUN_UP) || (state == RUN_DN) || (state == DEAD);
  assign fault    = (state == FAULT);

endmodule : motor_chan

// File: rtl/motor_ctrl_multi.sv
// -----------------------------------------------------------------------------
// motor_ctrl_multi
//
// Purpose : N_CH independent limit-switch motor channels with press-to-reverse
//           dead time, run watchdog and latched fault handling. Sits between
//           debounced operator/limit inputs and the motor power-stage drivers.
//
// Ports   :
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   activate   in   [N_CH] per-channel request level, rising edge acts
//   up_limit   in   [N_CH] per-channel upper end-stop
//   dn_limit   in   [N_CH] per-channel lower end-stop
//   timeout    in   [TMO_W] shared max motor-on cycles per travel, 0 = off
//   fault_clr  in   [N_CH] per-channel fault acknowledge
//   motor_up   out  [N_CH] drive up
//   motor_dn   out  [N_CH] drive down
//   busy       out  [N_CH] running or in dead time
//   fault      out  [N_CH] latched fault
// -----------------------------------------------------------------------------
module motor_ctrl_multi
  import motor_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned TMO_W       = 16,
  parameter int unsigned DEAD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   activate,
  input  logic [N_CH-1:0]   up_limit,
  input  logic [N_CH-1:0]   dn_limit,
  input  logic [TMO_W-1:0]  timeout,
  input  logic [N_CH-1:0]   fault_clr,
  output logic [N_CH-1:0]   motor_up,
  output logic [N_CH-1:0]   motor_dn,
  output logic [N_CH-1:0]   busy,
  output logic [N_CH-1:0]   fault
);

  // One self-contained FSM per channel; only clock, reset and the watchdog
  // limit are shared.
  for (genvar ch = 0; ch < N_CH; ch++) begin : g_chan
    motor_chan #(
      .TMO_W       (TMO_W),
      .DEAD_CYCLES (DEAD_CYCLES)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .activate  (activate[ch]),
      .up_limit  (up_limit[ch]),
      .dn_limit  (dn_limit[ch]),
      .timeout   (timeout),
      .fault_clr (fault_clr[ch]),
      .motor_up  (motor_up[ch]),
      .motor_dn  (motor_dn[ch]),
      .busy      (busy[ch]),
      .fault     (fault[ch])
    );
  end

endmodule : motor_ctrl_multi

// File: tb/tb_motor_ctrl_multi.sv
// -----------------------------------------------------------------------------
// tb_motor_ctrl_multi
//
// Self-checking bench for motor_ctrl_multi: directed scenarios followed by
// randomized stimulus, all compared cycle by cycle against a behavioural
// per-channel model that tracks motion as flags plus remaining-cycle counts.
// -----------------------------------------------------------------------------
module tb_motor_ctrl_multi;

  localparam int N_CH        = 4;
  localparam int TMO_W       = 16;
  localparam int DEAD_CYCLES = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N_CH-1:0]   activate, up_limit, dn_limit, fault_clr;
  logic [TMO_W-1:0]  timeout;
  logic [N_CH-1:0]   motor_up, motor_dn, busy, fault;

  always #5 clk = ~clk;

  motor_ctrl_multi #(
    .N_CH        (N_CH),
    .TMO_W       (TMO_W),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .activate  (activate),
    .up_limit  (up_limit),
    .dn_limit  (dn_limit),
    .timeout   (timeout),
    .fault_clr (fault_clr),
    .motor_up  (motor_up),
    .motor_dn  (motor_dn),
    .busy      (busy),
    .fault     (fault)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h want %0h", tag, $time, obs, exp);
    end
  endtask

  // Behavioural model: what the motor is doing, how long it has been on,
  // how much dead time remains, and which way it goes after the dead time.
  bit m_prev   [N_CH];
  bit m_up     [N_CH];
  bit m_dn     [N_CH];
  bit m_dead   [N_CH];
  bit m_flt    [N_CH];
  bit m_pendup [N_CH];
  int m_on     [N_CH];
  int m_dl     [N_CH];

  task automatic model_step(input logic r, input logic [N_CH-1:0] a, u, d, cl,
                            input logic [TMO_W-1:0] t);
    for (int c = 0; c < N_CH; c++) begin
      bit rise, both;
      if (r) begin
        m_prev[c] = 1; m_up[c] = 0; m_dn[c] = 0; m_dead[c] = 0; m_flt[c] = 0;
        m_on[c] = 0; m_dl[c] = 0;
      end else begin
        rise = a[c] && !m_prev[c];
        m_prev[c] = a[c];
        both = u[c] && d[c];
        if (m_flt[c]) begin
          if (cl[c] && !both) m_flt[c] = 0;
        end else if (both) begin
          m_up[c] = 0; m_dn[c] = 0; m_dead[c] = 0; m_flt[c] = 1;
        end else if (m_dead[c]) begin
          m_dl[c]--;
          if (m_dl[c] == 0) begin
            m_dead[c] = 0; m_up[c] = m_pendup[c]; m_dn[c] = !m_pendup[c]; m_on[c] = 0;
          end
        end else if (m_up[c] || m_dn[c]) begin
          m_on[c]++;
          if (m_up[c] ? u[c] : d[c]) begin
            m_up[c] = 0; m_dn[c] = 0;
          end else if (t != 0 && m_on[c] == int'(t)) begin
            m_up[c] = 0; m_dn[c] = 0; m_flt[c] = 1;
          end else if (rise) begin
            m_pendup[c] = m_dn[c];
            m_up[c] = 0; m_dn[c] = 0; m_dead[c] = 1; m_dl[c] = DEAD_CYCLES;
          end
        end else if (rise) begin
          m_up[c] = !u[c]; m_dn[c] = u[c]; m_on[c] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [N_CH-1:0] eu, ed, eb, ef;
    for (int c = 0; c < N_CH; c++) begin
      eu[c] = m_up[c];
      ed[c] = m_dn[c];
      eb[c] = m_up[c] | m_dn[c] | m_dead[c];
      ef[c] = m_flt[c];
    end
    chk("motor_up", 32'(motor_up), 32'(eu));
    chk("motor_dn", 32'(motor_dn), 32'(ed));
    chk("busy",     32'(busy),     32'(eb));
    chk("fault",    32'(fault),    32'(ef));
    chk("excl",     32'(motor_up & motor_dn), 32'd0);
  endtask

  // One clock: inputs as currently driven are sampled at the edge, then the
  // outputs are checked 1 time unit later.
  task automatic step();
    logic r;
    logic [N_CH-1:0] a, u, d, cl;
    logic [TMO_W-1:0] t;
    r = rst; a = activate; u = up_limit; d = dn_limit; cl = fault_clr; t = timeout;
    @(posedge clk);
    model_step(r, a, u, d, cl, t);
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int n, hi;
    bit done;

    rst = 1'b1; activate = '0; up_limit = '0; dn_limit = '0; fault_clr = '0;
    timeout = '0;
    #1;

    // Reset and basic up travel on ch0
    run(2);
    chk("rst_up",  32'(motor_up), 32'd0);
    chk("rst_flt", 32'(fault),    32'd0);
    rst = 1'b0;
    run(1);
    activate[0] = 1'b1;
    step();
    chk("start_up0", 32'(motor_up[0]), 32'd1);
    activate[0] = 1'b0;
    run(8);
    up_limit[0] = 1'b1;
    step();
    chk("stop_up0", 32'(motor_up[0]), 32'd0);
    chk("others",   32'(motor_up[3:1] | motor_dn[3:1]), 32'd0);
    up_limit[0] = 1'b0;
    run(2);

    // Down travel from the upper stop on ch1
    up_limit[1] = 1'b1;
    step();
    activate[1] = 1'b1;
    step();
    chk("start_dn1", 32'(motor_dn[1]), 32'd1);
    chk("busy1",     32'(busy[1]),     32'd1);
    activate[1] = 1'b0; up_limit[1] = 1'b0;
    run(5);
    dn_limit[1] = 1'b1;
    step();
    chk("stop_dn1", 32'(motor_dn[1]), 32'd0);
    chk("idle1",    32'(busy[1]),     32'd0);
    dn_limit[1] = 1'b0;
    run(2);

    // Reversal with dead time on ch2
    activate[2] = 1'b1;
    step();
    activate[2] = 1'b0;
    run(4);
    activate[2] = 1'b1;
    step();
    chk("rev_off", 32'(motor_up[2] | motor_dn[2]), 32'd0);
    activate[2] = 1'b0;
    n = 1; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      if (motor_up[2] | motor_dn[2]) done = 1; else n++;
    end
    chk("dead_len", 32'(n), 32'(DEAD_CYCLES));
    chk("rev_dn2",  32'(motor_dn[2]), 32'd1);
    dn_limit[2] = 1'b1;
    step();
    dn_limit[2] = 1'b0;
    run(2);

    // Watchdog on ch3
    timeout = 16'd20;
    activate[3] = 1'b1;
    step();
    activate[3] = 1'b0;
    hi = 0; done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (motor_up[3]) hi++; else done = 1;
      if (!done) step();
    end
    chk("wdog_len", 32'(hi), 32'd20);
    chk("wdog_flt", 32'(fault[3]), 32'd1);
    fault_clr[3] = 1'b1;
    step();
    fault_clr[3] = 1'b0;
    chk("wdog_clr", 32'(fault[3]), 32'd0);
    timeout = '0;
    activate[3] = 1'b1;
    step();
    activate[3] = 1'b0;
    run(60);
    chk("no_wdog", 32'(motor_up[3]), 32'd1);
    up_limit[3] = 1'b1;
    step();
    up_limit[3] = 1'b0;
    run(2);

    // Contradictory limits on ch0
    up_limit[0] = 1'b1; dn_limit[0] = 1'b1;
    step();
    chk("both_flt", 32'(fault[0]), 32'd1);
    fault_clr[0] = 1'b1;
    run(2);
    chk("clr_held", 32'(fault[0]), 32'd1);
    fault_clr[0] = 1'b0; dn_limit[0] = 1'b0;
    step();
    fault_clr[0] = 1'b1;
    step();
    chk("clr_ok", 32'(fault[0]), 32'd0);
    fault_clr[0] = 1'b0; up_limit[0] = 1'b0;
    run(2);

    // Request held through reset, then reset mid-travel on ch1
    activate[1] = 1'b1;
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(3);
    chk("held_rst", 32'(motor_up[1] | motor_dn[1]), 32'd0);
    activate[1] = 1'b0;
    step();
    activate[1] = 1'b1;
    step();
    chk("fresh_edge", 32'(motor_up[1]), 32'd1);
    run(3);
    rst = 1'b1;
    step();
    chk("rst_mid", 32'(motor_up[1]), 32'd0);
    rst = 1'b0; activate[1] = 1'b0;
    step();

    // Randomized traffic on all channels
    for (int blk = 0; blk < 6; blk++) begin
      timeout = (blk % 3 == 0) ? '0 : TMO_W'($urandom_range(3, 30));
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int cyc = 0; cyc < 500; cyc++) begin
        for (int c = 0; c < N_CH; c++) begin
          if ($urandom_range(0, 11) == 0) activate[c] = ~activate[c];
          up_limit[c]  = ($urandom_range(0, 19) == 0);
          dn_limit[c]  = ($urandom_range(0, 19) == 0);
          fault_clr[c] = ($urandom_range(0, 9) == 0);
        end
        rst = ($urandom_range(0, 299) == 0);
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_motor_ctrl_multi
